// File: rtl/kch_table_if.sv
// kch_table_if: bundle of advert, selection and status signals for kch_table.
//   master modport (upstream controller):
//     drives   en_KCH, HB_reset, fCH_ID, fCH_Hops, fCH_QValue, sel_req
//     observes busy, sel_valid, chosenCH, hopsfromCH, chosenQ, kch_count, overflow
//   slave modport (the table itself): the mirror image of master.
interface kch_table_if #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 16
) ();
    localparam int IDX_W = $clog2(DEPTH);

    logic                  en_KCH;
    logic                  HB_reset;
    logic [WORD_WIDTH-1:0] fCH_ID;
    logic [WORD_WIDTH-1:0] fCH_Hops;
    logic [WORD_WIDTH-1:0] fCH_QValue;
    logic                  sel_req;
    logic                  busy;
    logic                  sel_valid;
    logic [WORD_WIDTH-1:0] chosenCH;
    logic [WORD_WIDTH-1:0] hopsfromCH;
    logic [WORD_WIDTH-1:0] chosenQ;
    logic [IDX_W:0]        kch_count;
    logic                  overflow;

    modport master (
        output en_KCH, HB_reset, fCH_ID, fCH_Hops, fCH_QValue, sel_req,
        input  busy, sel_valid, chosenCH, hopsfromCH, chosenQ, kch_count, overflow
    );

    modport slave (
        input  en_KCH, HB_reset, fCH_ID, fCH_Hops, fCH_QValue, sel_req,
        output busy, sel_valid, chosenCH, hopsfromCH, chosenQ, kch_count, overflow
    );
endinterface

// File: rtl/kch_table.sv
// kch_table: cluster-head table. Records cluster-head adverts (ID, hop count,
// Q-value) and, on request, scans the valid entries one per cycle to pick the
// best cluster head (fewest hops, then highest Q, then lowest ID).
//   clk  : sole clock, rising edge
//   nrst : synchronous active-low reset
//   bus  : kch_table_if.slave
//          en_KCH + fCH_*  advert strobe and fields (ID 0 is ignored)
//          HB_reset        heartbeat flush of the table / abort of a selection
//          sel_req         start a selection scan
//          busy, sel_valid scan in progress / one-cycle result strobe
//          chosenCH, hopsfromCH, chosenQ  winning entry (held between selections)
//          kch_count       number of valid entries
//          overflow        sticky flag: an advert was dropped
// Optional feature: define KCH_REPLACE_EN to let an advert replace the
// worst-ranked entry of a full table when it ranks strictly better.
module kch_table #(
    parameter int WORD_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input logic        clk,
    input logic        nrst,
    kch_table_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] CNT_ONE    = (IDX_W+1)'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t state, next_state;

    logic [DEPTH-1:0]      valid;
    logic [WORD_WIDTH-1:0] ids  [DEPTH];
    logic [WORD_WIDTH-1:0] hops [DEPTH];
    logic [WORD_WIDTH-1:0] qs   [DEPTH];

    logic [IDX_W:0]        count;
    logic                  overflow;
    logic [IDX_W:0]        scan_idx;
    logic [IDX_W-1:0]      scan_ptr;

    logic                  best_found;
    logic [WORD_WIDTH-1:0] best_id, best_hops, best_q;
    logic [WORD_WIDTH-1:0] chosen_id, chosen_hops, chosen_q;

    logic                  fsm_busy, fsm_done;

    logic                  advert_ok;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  do_write, do_inc, set_ovf;
    logic [IDX_W-1:0]      wr_idx;

    // True when entry a ranks strictly better than entry b.
    function automatic logic ranks_better(
        input logic [WORD_WIDTH-1:0] h_a, q_a, id_a,
        input logic [WORD_WIDTH-1:0] h_b, q_b, id_b
    );
        if (h_a != h_b) return h_a < h_b;
        if (q_a != q_b) return q_a > q_b;
        return id_a < id_b;
    endfunction

    assign scan_ptr  = scan_idx[IDX_W-1:0];
    assign advert_ok = bus.en_KCH && (state == IDLE) && (bus.fCH_ID != '0);

    // Look for an existing entry with the advertised ID.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && valid[i] && (ids[i] == bus.fCH_ID)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

`ifdef KCH_REPLACE_EN
    logic [IDX_W-1:0] worst_idx;

    // Worst-ranked entry; only consulted when the table is full, so every
    // slot is valid. "Not better than" lets equal ranks move to the higher index.
    always_comb begin
        worst_idx = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (!ranks_better(hops[i], qs[i], ids[i],
                              hops[worst_idx], qs[worst_idx], ids[worst_idx])) begin
                worst_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Decide what an advert does: refresh, append, replace or drop.
    always_comb begin
        do_write = 1'b0;
        do_inc   = 1'b0;
        set_ovf  = 1'b0;
        wr_idx   = '0;
        if (advert_ok) begin
            if (hit) begin
                do_write = 1'b1;
                wr_idx   = hit_idx;
            end else if (count != FULL_COUNT) begin
                do_write = 1'b1;
                do_inc   = 1'b1;
                wr_idx   = count[IDX_W-1:0];
            end else begin
`ifdef KCH_REPLACE_EN
                if (ranks_better(bus.fCH_Hops, bus.fCH_QValue, bus.fCH_ID,
                                 hops[worst_idx], qs[worst_idx], ids[worst_idx])) begin
                    do_write = 1'b1;
                    wr_idx   = worst_idx;
                end else begin
                    set_ovf = 1'b1;
                end
`else
                set_ovf = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // SCAN runs kch_count+1 cycles: one per entry plus a final cycle that
    // publishes the winner, giving a sel_req to sel_valid latency of count+2.
    always_comb begin
        next_state = state;
        fsm_busy   = 1'b0;
        fsm_done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sel_req) next_state = SCAN;
            end
            SCAN: begin
                fsm_busy = 1'b1;
                if (scan_idx >= count) next_state = DONE;
            end
            DONE: begin
                fsm_busy   = 1'b1;
                fsm_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (bus.HB_reset) next_state = IDLE;
    end

    // Table contents, counters and the running best of a scan. The heartbeat
    // clear shares the reset path so it wins over any simultaneous request.
    always_ff @(posedge clk) begin
        if (!nrst || bus.HB_reset) begin
            valid       <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            scan_idx    <= '0;
            best_found  <= 1'b0;
            best_id     <= '0;
            best_hops   <= '1;
            best_q      <= '0;
            chosen_id   <= '0;
            chosen_hops <= '1;
            chosen_q    <= '0;
        end else begin
            if (do_write) begin
                valid[wr_idx] <= 1'b1;
                ids[wr_idx]   <= bus.fCH_ID;
                hops[wr_idx]  <= bus.fCH_Hops;
                qs[wr_idx]    <= bus.fCH_QValue;
            end
            if (do_inc)  count    <= count + CNT_ONE;
            if (set_ovf) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.sel_req) begin
                        scan_idx   <= '0;
                        best_found <= 1'b0;
                        best_id    <= '0;
                        best_hops  <= '1;
                        best_q     <= '0;
                    end
                end
                SCAN: begin
                    if (scan_idx < count) begin
                        if (!best_found ||
                            ranks_better(hops[scan_ptr], qs[scan_ptr], ids[scan_ptr],
                                         best_hops, best_q, best_id)) begin
                            best_id   <= ids[scan_ptr];
                            best_hops <= hops[scan_ptr];
                            best_q    <= qs[scan_ptr];
                        end
                        best_found <= 1'b1;
                        scan_idx   <= scan_idx + CNT_ONE;
                    end else begin
                        chosen_id   <= best_id;
                        chosen_hops <= best_hops;
                        chosen_q    <= best_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = fsm_busy;
    assign bus.sel_valid  = fsm_done;
    assign bus.chosenCH   = chosen_id;
    assign bus.hopsfromCH = chosen_hops;
    assign bus.chosenQ    = chosen_q;
    assign bus.kch_count  = count;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_kch_table.sv
// tb_kch_table: directed, table-driven bench for kch_table (WORD_WIDTH=16,
// DEPTH=16). Expectations for the full-table case follow KCH_REPLACE_EN.
module tb_kch_table;
    localparam int WW = 16;
    localparam int DP = 16;

    typedef enum int {OP_ADV, OP_SEL, OP_HB} op_t;

    typedef struct {
        op_t op;
        int  id, hops, q;
        int  exp_count, exp_ovf;
        int  exp_id, exp_hops, exp_q;
        int  exp_lat;
    } vec_t;

    logic clk;
    logic nrst;
    int   n_vectors;
    int   n_miscompares;
    vec_t vecs[$];

    kch_table_if #(.WORD_WIDTH(WW), .DEPTH(DP)) bus_if ();

    kch_table #(.WORD_WIDTH(WW), .DEPTH(DP)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input op_t op, input int id, input int h, input int q,
                                input int cnt, input int ovf, input int eid,
                                input int eh, input int eq, input int lat);
        vec_t v;
        v.op = op; v.id = id; v.hops = h; v.q = q;
        v.exp_count = cnt; v.exp_ovf = ovf;
        v.exp_id = eid; v.exp_hops = eh; v.exp_q = eq; v.exp_lat = lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendAdvert(input int id, input int h, input int q);
        bus_if.en_KCH     = 1'b1;
        bus_if.fCH_ID     = WW'(id);
        bus_if.fCH_Hops   = WW'(h);
        bus_if.fCH_QValue = WW'(q);
        @(negedge clk);
        bus_if.en_KCH = 1'b0;
    endtask

    task automatic pulseHb();
        bus_if.HB_reset = 1'b1;
        @(negedge clk);
        bus_if.HB_reset = 1'b0;
    endtask

    // mode 0: plain select; 1: advert + sel_req during the first busy cycle;
    // 2: advert issued in the same cycle as sel_req. Returns latency or -1.
    task automatic runSelect(input int mode, input int aid, input int ah, input int aq,
                             output int lat);
        int cycles;
        bus_if.sel_req = 1'b1;
        if (mode == 2) begin
            bus_if.en_KCH     = 1'b1;
            bus_if.fCH_ID     = WW'(aid);
            bus_if.fCH_Hops   = WW'(ah);
            bus_if.fCH_QValue = WW'(aq);
        end
        @(negedge clk);
        bus_if.sel_req = 1'b0;
        bus_if.en_KCH  = 1'b0;
        cycles = 1;
        if (mode == 1) begin
            bus_if.en_KCH     = 1'b1;
            bus_if.fCH_ID     = WW'(aid);
            bus_if.fCH_Hops   = WW'(ah);
            bus_if.fCH_QValue = WW'(aq);
            bus_if.sel_req    = 1'b1;
            @(negedge clk);
            cycles++;
            bus_if.en_KCH  = 1'b0;
            bus_if.sel_req = 1'b0;
        end
        while (bus_if.sel_valid !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        lat = (bus_if.sel_valid === 1'b1) ? cycles : -1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, output int lat);
        lat = 0;
        case (v.op)
            OP_ADV: sendAdvert(v.id, v.hops, v.q);
            OP_SEL: runSelect(0, 0, 0, 0, lat);
            OP_HB:  pulseHb();
            default: ;
        endcase
    endtask

    task automatic checkState(input string tag, input int cnt, input int ovf,
                              input int eid, input int eh, input int eq);
        checkOutput({tag, "_count"},  32'(bus_if.kch_count),  cnt);
        checkOutput({tag, "_ovf"},    32'(bus_if.overflow),   ovf);
        checkOutput({tag, "_chosen"}, 32'(bus_if.chosenCH),   eid);
        checkOutput({tag, "_hops"},   32'(bus_if.hopsfromCH), eh);
        checkOutput({tag, "_q"},      32'(bus_if.chosenQ),    eq);
    endtask

    initial begin
        int lat;
        int seen;
        n_vectors       = 0;
        n_miscompares   = 0;
        nrst            = 1'b0;
        bus_if.en_KCH   = 1'b0;
        bus_if.HB_reset = 1'b0;
        bus_if.sel_req  = 1'b0;
        bus_if.fCH_ID   = '0;
        bus_if.fCH_Hops = '0;
        bus_if.fCH_QValue = '0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        checkState("reset", 0, 0, 0, 65535, 0);
        checkOutput("reset_busy",  32'(bus_if.busy),      0);
        checkOutput("reset_valid", 32'(bus_if.sel_valid), 0);

        vecs.push_back(mk(OP_SEL, 0, 0, 0,      0, 0, 0, 65535, 0, 2));
        vecs.push_back(mk(OP_ADV, 5, 3, 10,     1, 0, 0, 65535, 0, 0));
        vecs.push_back(mk(OP_ADV, 7, 2, 4,      2, 0, 0, 65535, 0, 0));
        vecs.push_back(mk(OP_ADV, 9, 2, 8,      3, 0, 0, 65535, 0, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      3, 0, 9, 2, 8, 5));
        vecs.push_back(mk(OP_ADV, 0, 1, 99,     3, 0, 9, 2, 8, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      3, 0, 9, 2, 8, 5));
        vecs.push_back(mk(OP_ADV, 7, 2, 8,      3, 0, 9, 2, 8, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      3, 0, 7, 2, 8, 5));
        vecs.push_back(mk(OP_ADV, 7, 6, 1,      3, 0, 7, 2, 8, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      3, 0, 9, 2, 8, 5));
        vecs.push_back(mk(OP_HB,  0, 0, 0,      0, 0, 0, 65535, 0, 0));
        vecs.push_back(mk(OP_ADV, 4, 2, 8,      1, 0, 0, 65535, 0, 0));
        vecs.push_back(mk(OP_ADV, 3, 2, 8,      2, 0, 0, 65535, 0, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      2, 0, 3, 2, 8, 4));
        vecs.push_back(mk(OP_ADV, 3, 5, 8,      2, 0, 3, 2, 8, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      2, 0, 4, 2, 8, 4));
        vecs.push_back(mk(OP_ADV, 20, 2, 9,     3, 0, 4, 2, 8, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      3, 0, 20, 2, 9, 5));
        vecs.push_back(mk(OP_ADV, 21, 1, 0,     4, 0, 20, 2, 9, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      4, 0, 21, 1, 0, 6));
        vecs.push_back(mk(OP_ADV, 23, 1, 65535, 5, 0, 21, 1, 0, 0));
        vecs.push_back(mk(OP_SEL, 0, 0, 0,      5, 0, 23, 1, 65535, 7));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            applyStimulus(vecs[i], lat);
            if (vecs[i].op == OP_SEL) checkOutput({tag, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            checkState(tag, vecs[i].exp_count, vecs[i].exp_ovf,
                       vecs[i].exp_id, vecs[i].exp_hops, vecs[i].exp_q);
            checkOutput({tag, "_busy"},  32'(bus_if.busy),      0);
            checkOutput({tag, "_valid"}, 32'(bus_if.sel_valid), 0);
        end

        // Advert in the same cycle as sel_req joins the scan.
        runSelect(2, 30, 0, 1, lat);
        checkOutput("same_cycle_latency", 32'(lat), 8);
        checkState("same_cycle", 6, 0, 30, 0, 1);

        // Advert and sel_req while busy are ignored.
        runSelect(1, 40, 0, 100, lat);
        checkOutput("busy_adv_latency", 32'(lat), 8);
        checkState("busy_adv", 6, 0, 30, 0, 1);
        runSelect(0, 0, 0, 0, lat);
        checkOutput("busy_adv_again_latency", 32'(lat), 8);
        checkState("busy_adv_again", 6, 0, 30, 0, 1);

        // Full table with hops=5, then a better new advert.
        pulseHb();
        for (int k = 1; k <= DP; k++) sendAdvert(k, 5, k);
        checkState("full", 16, 0, 0, 65535, 0);
        sendAdvert(99, 1, 0);
`ifdef KCH_REPLACE_EN
        checkState("full_adv99", 16, 0, 0, 65535, 0);
        runSelect(0, 0, 0, 0, lat);
        checkOutput("full_sel_latency", 32'(lat), 18);
        checkState("full_sel", 16, 0, 99, 1, 0);
        sendAdvert(100, 9, 0);
        checkState("full_adv100", 16, 1, 99, 1, 0);
`else
        checkState("full_adv99", 16, 1, 0, 65535, 0);
        runSelect(0, 0, 0, 0, lat);
        checkOutput("full_sel_latency", 32'(lat), 18);
        checkState("full_sel", 16, 1, 16, 5, 16);
        sendAdvert(100, 9, 0);
        checkState("full_adv100", 16, 1, 16, 5, 16);
`endif
        pulseHb();
        checkState("full_hb", 0, 0, 0, 65535, 0);

        // Heartbeat clear in the middle of an 8-entry scan.
        for (int k = 1; k <= 8; k++) sendAdvert(k, 5, k);
        runSelect(0, 0, 0, 0, lat);
        checkOutput("hb_pre_latency", 32'(lat), 10);
        checkState("hb_pre", 8, 0, 8, 5, 8);
        bus_if.sel_req = 1'b1;
        @(negedge clk);
        bus_if.sel_req = 1'b0;
        @(negedge clk);
        bus_if.HB_reset   = 1'b1;
        bus_if.en_KCH     = 1'b1;
        bus_if.sel_req    = 1'b1;
        bus_if.fCH_ID     = 16'd50;
        bus_if.fCH_Hops   = 16'd1;
        bus_if.fCH_QValue = 16'd1;
        @(negedge clk);
        bus_if.HB_reset = 1'b0;
        bus_if.en_KCH   = 1'b0;
        bus_if.sel_req  = 1'b0;
        checkOutput("hb_scan_busy", 32'(bus_if.busy), 0);
        checkState("hb_scan", 0, 0, 0, 65535, 0);
        seen = 0;
        repeat (12) begin
            if (bus_if.sel_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checkOutput("hb_scan_no_valid", 32'(seen), 0);

        // Heartbeat clear beats a simultaneous advert and sel_req in IDLE.
        bus_if.HB_reset   = 1'b1;
        bus_if.en_KCH     = 1'b1;
        bus_if.sel_req    = 1'b1;
        bus_if.fCH_ID     = 16'd51;
        @(negedge clk);
        bus_if.HB_reset = 1'b0;
        bus_if.en_KCH   = 1'b0;
        bus_if.sel_req  = 1'b0;
        checkOutput("hb_prio_busy",  32'(bus_if.busy),      0);
        checkOutput("hb_prio_count", 32'(bus_if.kch_count), 0);

        // Reset in the middle of a scan.
        for (int k = 1; k <= 3; k++) sendAdvert(k + 60, k, 0);
        bus_if.sel_req = 1'b1;
        @(negedge clk);
        bus_if.sel_req = 1'b0;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        checkOutput("nrst_scan_busy", 32'(bus_if.busy), 0);
        checkState("nrst_scan", 0, 0, 0, 65535, 0);
        seen = 0;
        repeat (8) begin
            if (bus_if.sel_valid === 1'b1) seen++;
            @(negedge clk);
        end
        checkOutput("nrst_scan_no_valid", 32'(seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/kch_table.md
KCH_TABLE -- requirements
Module: kch_table

Interface
REQ-001 Parameter WORD_WIDTH, default 16: width of the ID, hop and Q-value fields.
REQ-002 Parameter DEPTH, default 16, legal range 2..64: number of cluster-head entries; IDX_W = clog2(DEPTH).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 en_KCH  input  1  one-cycle strobe: record the cluster-head advert on fCH_*.
REQ-006 HB_reset  input  1  heartbeat clear: flush the table and abort any selection.
REQ-007 fCH_ID / fCH_Hops / fCH_QValue  input  WORD_WIDTH each  advert ID, hop count and Q-value.
REQ-008 sel_req  input  1  one-cycle strobe: start best-CH selection.
REQ-009 busy  output  1  high while a selection scan is running.
REQ-010 sel_valid  output  1  one-cycle pulse: chosen outputs have been updated.
REQ-011 chosenCH / hopsfromCH / chosenQ  output  WORD_WIDTH each  winning ID, hops and Q-value.
REQ-012 kch_count  output  IDX_W+1  number of valid entries.
REQ-013 overflow  output  1  sticky: an advert was dropped.

Function
REQ-014 Each entry SHALL hold valid, ID, hops and Q; ID 0 is reserved, and en_KCH with fCH_ID==0 SHALL be ignored.
REQ-015 On en_KCH in IDLE: if a valid entry has ID==fCH_ID, its hops and Q SHALL be overwritten at the next edge and kch_count SHALL stay unchanged.
REQ-016 Otherwise, if kch_count<DEPTH, the advert SHALL be written to slot kch_count and kch_count SHALL increment at the same edge.
REQ-017 Otherwise (table full), the behaviour SHALL follow REQ-030/REQ-031.
REQ-018 en_KCH while busy SHALL be ignored with no state change; upstream holds adverts until busy is low.
REQ-019 The FSM states SHALL be IDLE, SCAN and DONE.
REQ-020 Transitions: IDLE->SCAN on sel_req; SCAN examines entry i at scan cycle i for i=0..kch_count-1, then moves to DONE; DONE->IDLE unconditionally.
REQ-021 Ranking SHALL be: fewer hops wins; on equal hops, higher Q wins; on equal hops and Q, lower ID wins; comparisons are unsigned.
REQ-022 busy SHALL be high in SCAN and DONE.
REQ-023 sel_valid SHALL be high only in DONE, and the chosen outputs SHALL update on entry to DONE; latency is sel_req to sel_valid = kch_count+2 cycles.
REQ-024 Empty table: SCAN lasts one cycle, then DONE with chosenCH=0, hopsfromCH=all-ones and chosenQ=0.
REQ-025 sel_req together with en_KCH in IDLE: the insert SHALL be applied first, and the scan SHALL include the new entry.
REQ-026 sel_req while busy SHALL be ignored.
REQ-027 HB_reset SHALL clear all valid bits, kch_count and overflow, force IDLE with no sel_valid, and return the chosen outputs to their reset values.
REQ-028 HB_reset SHALL take priority over simultaneous en_KCH and sel_req.
REQ-029 Chosen outputs SHALL hold their values between selections.

Configuration
REQ-030 Without macro KCH_REPLACE_EN: an advert with a new ID arriving while the table is full SHALL be dropped and overflow set.
REQ-031 With KCH_REPLACE_EN: a full table SHALL combinationally find the worst-ranked valid entry (ties: highest index) and overwrite it with the advert if the advert ranks strictly better; otherwise the advert SHALL be dropped and overflow set.

Reset
REQ-032 With nrst low at a clock edge: state=IDLE, all valid=0, kch_count=0, overflow=0, busy=0, sel_valid=0, chosenCH=0, hopsfromCH=all-ones, chosenQ=0.
REQ-033 Reset mid-scan SHALL abort the scan with no sel_valid.

Verification
REQ-034 Insert (ID5,h3,Q10), (ID7,h2,Q4), (ID9,h2,Q8), then sel_req -> sel_valid 5 cycles after sel_req; chosenCH=9, hopsfromCH=2, chosenQ=8.
REQ-035 Insert (ID4,h2,Q8), (ID3,h2,Q8), then select -> chosenCH=3; re-advertise ID3 with h5, select -> chosenCH=4 and kch_count=2.
REQ-036 Fill DEPTH=16 with hops=5, then advert ID99,h1 -> macro off: overflow=1, count=16, select not 99; macro on: select returns 99, overflow=0.
REQ-037 sel_req on an empty table -> sel_valid 2 cycles later, chosenCH=0, hopsfromCH=16'hFFFF.
REQ-038 HB_reset during SCAN of 8 entries -> busy drops next cycle, no sel_valid, count=0, chosen outputs at reset values.
REQ-039 en_KCH asserted while busy -> table and count unchanged; en_KCH with ID 0 -> ignored.
